// File: rtl/op1_share_arbiter.sv
// ---------------------------------------------------------------------------
// op1_share_arbiter
//
// Round-robin arbiter/sequencer sharing a single operation1 datapath among
// NUM_REQ requesters. One operation is in flight at a time. The result is
// routed back to the requester that issued it.
//
// Optional feature macro: OP1_ARB_WATCHDOG_EN
//   defined   : a WAIT-state timeout of WATCHDOG_CYCLES cycles produces a
//               response with rsp_result=0 and rsp_err=1.
//   undefined : WAIT lasts until the datapath strobes a result; rsp_err is
//               always 0.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous, active-low reset
//   req_valid/req_ready   per-requester command handshake (ready is one-hot)
//   req_oper              operands, requester i at [i*4*W +: 4*W] = {a,b,c,d}
//   rsp_valid/rsp_ready   per-requester result handshake (valid is one-hot)
//   rsp_result, rsp_err   shared result and timeout flag
//   dp_input_a..d         operands to the datapath
//   dp_input_STB          operand strobe, accepted when dp_BUSY is low
//   dp_BUSY               datapath cannot accept operands
//   dp_output_result      datapath result
//   dp_output_STB         datapath result strobe
//   dp_output_module_BUSY low only while waiting for a result
//   owner                 current or last granted requester index
// ---------------------------------------------------------------------------
module op1_share_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int OPER_WIDTH      = 32,
    parameter int WATCHDOG_CYCLES = 1023,
    localparam int OW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*4*OPER_WIDTH-1:0] req_oper,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [OPER_WIDTH-1:0]           rsp_result,
    output logic                            rsp_err,
    output logic [OPER_WIDTH-1:0]           dp_input_a,
    output logic [OPER_WIDTH-1:0]           dp_input_b,
    output logic [OPER_WIDTH-1:0]           dp_input_c,
    output logic [OPER_WIDTH-1:0]           dp_input_d,
    output logic                            dp_input_STB,
    input  logic                            dp_BUSY,
    input  logic [OPER_WIDTH-1:0]           dp_output_result,
    input  logic                            dp_output_STB,
    output logic                            dp_output_module_BUSY,
    output logic [OW-1:0]                   owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                    state_reg, state_next;
    logic [OW-1:0]             rr_ptr_reg;
    logic [OW-1:0]             owner_reg;
    logic [OPER_WIDTH-1:0]     a_reg, b_reg, c_reg, d_reg;
    logic                      stb_reg;
    logic [OPER_WIDTH-1:0]     result_reg;
    logic                      err_reg;
    logic [NUM_REQ-1:0]        rsp_valid_reg;

    logic [NUM_REQ-1:0]        grant;
    logic [OW-1:0]             grant_idx;
    logic                      accept;
    logic                      handshake;
    logic                      result_take;
    logic                      timeout;
    logic                      resp_done;
    logic [OW-1:0]             owner_plus1;

    // Operand bundle per requester, {a,b,c,d} with a in the MSBs.
    logic [4*OPER_WIDTH-1:0]   oper_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_oper
        assign oper_arr[gi] = req_oper[gi*4*OPER_WIDTH +: 4*OPER_WIDTH];
    end

    // First asserted req_valid at or after rr_ptr, wrapping upward.
    always_comb begin
        int idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = OW'(idx);
            end
        end
    end

    // Held at zero while reset is asserted so the accept is never visible
    // during reset even though it is combinational.
    assign req_ready = (state_reg == S_IDLE && rst) ? grant : '0;

    assign accept      = (state_reg == S_IDLE) && (|grant);
    assign handshake   = (state_reg == S_ISSUE) && !dp_BUSY;
    assign result_take = (state_reg == S_WAIT) && dp_output_STB;
    assign resp_done   = (state_reg == S_RESP) && rsp_ready[owner_reg];

    // Wrap explicitly so non-power-of-two NUM_REQ works; NUM_REQ=1 stays 0.
    assign owner_plus1 = (owner_reg == OW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

`ifdef OP1_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_reg;

    // Held at zero outside WAIT, so it is clear on every entry to WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_reg <= '0;
        end else if (state_reg != S_WAIT) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end

    // Fires at the end of the WATCHDOG_CYCLES-th WAIT cycle; a real result
    // in that same cycle takes priority.
    assign timeout = (state_reg == S_WAIT) && !dp_output_STB &&
                     (wd_cnt_reg == WD_W'(WATCHDOG_CYCLES - 1));
`else
    logic unused_wd_cfg;
    assign unused_wd_cfg = (WATCHDOG_CYCLES == 0);
    assign timeout       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept)                 state_next = S_ISSUE;
            S_ISSUE: if (handshake)              state_next = S_WAIT;
            S_WAIT:  if (result_take || timeout) state_next = S_RESP;
            S_RESP:  if (resp_done)              state_next = S_IDLE;
            default:                             state_next = S_IDLE;
        endcase
    end

    // Datapath and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            c_reg         <= '0;
            d_reg         <= '0;
            stb_reg       <= 1'b0;
            result_reg    <= '0;
            err_reg       <= 1'b0;
            rsp_valid_reg <= '0;
        end else begin
            if (accept) begin
                {a_reg, b_reg, c_reg, d_reg} <= oper_arr[grant_idx];
                owner_reg <= grant_idx;
                stb_reg   <= 1'b1;
            end
            if (handshake) begin
                stb_reg <= 1'b0;
            end
            if (result_take) begin
                result_reg    <= dp_output_result;
                err_reg       <= 1'b0;
                rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
            end else if (timeout) begin
                result_reg    <= '0;
                err_reg       <= 1'b1;
                rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
            end
            if (resp_done) begin
                rsp_valid_reg <= '0;
                rr_ptr_reg    <= owner_plus1;
            end
        end
    end

    assign dp_input_a            = a_reg;
    assign dp_input_b            = b_reg;
    assign dp_input_c            = c_reg;
    assign dp_input_d            = d_reg;
    assign dp_input_STB          = stb_reg;
    assign dp_output_module_BUSY = (state_reg != S_WAIT);
    assign rsp_valid             = rsp_valid_reg;
    assign rsp_result            = result_reg;
    assign rsp_err               = err_reg;
    assign owner                 = owner_reg;

endmodule

// File: tb/tb_op1_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_op1_share_arbiter
//
// Directed testbench for op1_share_arbiter (NUM_REQ=4, OPER_WIDTH=32,
// WATCHDOG_CYCLES=16). The bench plays the datapath itself, driving
// dp_BUSY / dp_output_* directly. Outputs are sampled 1 ns or more after the
// rising edge; inputs are driven in the same window.
// ---------------------------------------------------------------------------
module tb_op1_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*4*W-1:0] req_oper = '0;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready = '0;
    logic [W-1:0]     rsp_result;
    logic             rsp_err;
    logic [W-1:0]     dp_input_a, dp_input_b, dp_input_c, dp_input_d;
    logic             dp_input_STB;
    logic             dp_BUSY = 1'b0;
    logic [W-1:0]     dp_output_result = '0;
    logic             dp_output_STB = 1'b0;
    logic             dp_output_module_BUSY;
    logic [1:0]       owner;

    int total = 0;
    int bad   = 0;

    op1_share_arbiter #(
        .NUM_REQ(N),
        .OPER_WIDTH(W),
        .WATCHDOG_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_oper(req_oper),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_err(rsp_err),
        .dp_input_a(dp_input_a),
        .dp_input_b(dp_input_b),
        .dp_input_c(dp_input_c),
        .dp_input_d(dp_input_d),
        .dp_input_STB(dp_input_STB),
        .dp_BUSY(dp_BUSY),
        .dp_output_result(dp_output_result),
        .dp_output_STB(dp_output_STB),
        .dp_output_module_BUSY(dp_output_module_BUSY),
        .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_oper(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d);
        req_oper[idx*4*W +: 4*W] = {a, b, c, d};
    endtask

    task automatic test_reset();
        #1;
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0000", rsp_valid); end
        total++; if (rsp_result !== 32'h0) begin bad++; $display("FAIL rst_rsp_result got=%h exp=0", rsp_result); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
        total++; if ({dp_input_a, dp_input_b, dp_input_c, dp_input_d} !== 128'h0) begin bad++; $display("FAIL rst_dp_input got=%h exp=0", {dp_input_a, dp_input_b, dp_input_c, dp_input_d}); end
        total++; if (dp_input_STB !== 1'b0) begin bad++; $display("FAIL rst_dp_stb got=%b exp=0", dp_input_STB); end
        total++; if (dp_output_module_BUSY !== 1'b1) begin bad++; $display("FAIL rst_module_busy got=%b exp=1", dp_output_module_BUSY); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL rst_owner got=%0d exp=0", owner); end
        req_valid = 4'b1111;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_oper(0, 32'd1, 32'd2, 32'd3, 32'd4);
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        total++; if (dp_input_STB !== 1'b1) begin bad++; $display("FAIL single_stb got=%b exp=1", dp_input_STB); end
        total++; if ({dp_input_a, dp_input_b, dp_input_c, dp_input_d} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin bad++; $display("FAIL single_operands got=%h exp=%h", {dp_input_a, dp_input_b, dp_input_c, dp_input_d}, {32'd1, 32'd2, 32'd3, 32'd4}); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_issue got=%b exp=0000", req_ready); end
        tick();
        total++; if (dp_input_STB !== 1'b0 || dp_output_module_BUSY !== 1'b0) begin bad++; $display("FAIL single_wait got stb=%b busy=%b exp stb=0 busy=0", dp_input_STB, dp_output_module_BUSY); end
        repeat (4) tick();
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_early_rsp got=%b exp=0000", rsp_valid); end
        dp_output_result = 32'h0000_000A;
        dp_output_STB = 1'b1;
        tick();
        dp_output_STB = 1'b0;
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
        total++; if (rsp_result !== 32'h0000_000A) begin bad++; $display("FAIL single_rsp_result got=%h exp=0000000a", rsp_result); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL single_rsp_err got=%b exp=0", rsp_err); end
        $display("txn single owner=%0d result=%h err=%0d", owner, rsp_result, rsp_err);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_rsp_clear got=%b exp=0000", rsp_valid); end
        // rr_ptr should now be 1: with req0 and req1 valid, req1 wins.
        req_valid = 4'b0011;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_rr_ptr got=%b exp=0010", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_oh;
        int idx;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_oper(i, 32'(i*4+1), 32'(i*4+2), 32'(i*4+3), 32'(i*4+4));
        end
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            idx = n % N;
            exp_oh = 4'b0001 << idx;
            #1;
            total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", n, req_ready, exp_oh); end
            tick();
            total++; if (owner !== 2'(idx) || dp_input_a !== 32'(idx*4+1) || dp_input_d !== 32'(idx*4+4)) begin bad++; $display("FAIL rr_issue%0d got owner=%0d a=%0d d=%0d exp owner=%0d a=%0d d=%0d", n, owner, dp_input_a, dp_input_d, idx, idx*4+1, idx*4+4); end
            tick();
            dp_output_result = 32'h100 + 32'(n);
            dp_output_STB = 1'b1;
            tick();
            dp_output_STB = 1'b0;
            total++; if (rsp_valid !== exp_oh || rsp_result !== 32'h100 + 32'(n)) begin bad++; $display("FAIL rr_rsp%0d got valid=%b result=%h exp valid=%b result=%h", n, rsp_valid, rsp_result, exp_oh, 32'h100 + 32'(n)); end
            $display("txn rr owner=%0d result=%h err=%0d", owner, rsp_result, rsp_err);
            rsp_ready = ~exp_oh;
            tick();
            total++; if (rsp_valid !== exp_oh) begin bad++; $display("FAIL rr_nonowner_ready%0d got=%b exp=%b", n, rsp_valid, exp_oh); end
            rsp_ready = exp_oh;
            tick();
            rsp_ready = 4'b0000;
            total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rr_rsp_clear%0d got=%b exp=0000", n, rsp_valid); end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_dp_busy();
        logic busy_pat [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int hs = 0;
        dp_BUSY = 1'b1;
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL busy_grant got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            dp_BUSY = busy_pat[c];
            #1;
            if (dp_input_STB && !dp_BUSY) hs++;
            if (c < 4) begin
                total++; if (dp_input_STB !== 1'b1 || dp_input_a !== 32'd9 || dp_input_d !== 32'd12) begin bad++; $display("FAIL busy_hold%0d got stb=%b a=%0d d=%0d exp stb=1 a=9 d=12", c, dp_input_STB, dp_input_a, dp_input_d); end
            end
            tick();
        end
        dp_BUSY = 1'b0;
        total++; if (hs !== 1) begin bad++; $display("FAIL busy_handshakes got=%0d exp=1", hs); end
        total++; if (dp_output_module_BUSY !== 1'b0) begin bad++; $display("FAIL busy_in_wait got=%b exp=0", dp_output_module_BUSY); end
        dp_output_result = 32'h777;
        dp_output_STB = 1'b1;
        tick();
        dp_output_STB = 1'b0;
        total++; if (rsp_valid !== 4'b0100 || rsp_result !== 32'h777) begin bad++; $display("FAIL busy_rsp got valid=%b result=%h exp valid=0100 result=00000777", rsp_valid, rsp_result); end
        $display("txn busy owner=%0d result=%h err=%0d", owner, rsp_result, rsp_err);
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = 4'b0000;
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1000;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant got=%b exp=1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        dp_output_result = 32'h5555;
        dp_output_STB = 1'b1;
        tick();
        dp_output_STB = 1'b0;
        req_valid = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (rsp_valid !== 4'b1000 || rsp_result !== 32'h5555 || req_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold%0d got valid=%b result=%h ready=%b exp valid=1000 result=00005555 ready=0000", c, rsp_valid, rsp_result, req_ready); end
            tick();
        end
        $display("txn bp owner=%0d result=%h err=%0d", owner, rsp_result, rsp_err);
        rsp_ready = 4'b1000;
        tick();
        rsp_ready = 4'b0000;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_release got=%b exp=0100", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        total++; if (dp_output_module_BUSY !== 1'b0 || owner !== 2'd1) begin bad++; $display("FAIL midrst_setup got busy=%b owner=%0d exp busy=0 owner=1", dp_output_module_BUSY, owner); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (owner !== 2'd0 || dp_input_a !== 32'd0 || dp_input_STB !== 1'b0) begin bad++; $display("FAIL midrst_regs got owner=%0d a=%0d stb=%b exp owner=0 a=0 stb=0", owner, dp_input_a, dp_input_STB); end
        total++; if (dp_output_module_BUSY !== 1'b1 || rsp_valid !== 4'b0000 || rsp_result !== 32'h0) begin bad++; $display("FAIL midrst_outs got busy=%b valid=%b result=%h exp busy=1 valid=0000 result=0", dp_output_module_BUSY, rsp_valid, rsp_result); end
        tick();
        rst = 1'b1;
        dp_output_result = 32'hDEAD;
        dp_output_STB = 1'b1;
        tick();
        dp_output_STB = 1'b0;
        total++; if (rsp_valid !== 4'b0000 || rsp_result !== 32'h0) begin bad++; $display("FAIL midrst_stale got valid=%b result=%h exp valid=0000 result=0", rsp_valid, rsp_result); end
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_idle got=%b exp=0001", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_watchdog();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        repeat (15) tick();
        total++; if (rsp_valid !== 4'b0000 || dp_output_module_BUSY !== 1'b0) begin bad++; $display("FAIL wd_cycle16 got valid=%b busy=%b exp valid=0000 busy=0", rsp_valid, dp_output_module_BUSY); end
        tick();
`ifdef OP1_ARB_WATCHDOG_EN
        total++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_result !== 32'h0) begin bad++; $display("FAIL wd_timeout got valid=%b err=%b result=%h exp valid=0001 err=1 result=0", rsp_valid, rsp_err, rsp_result); end
        dp_output_result = 32'hBEEF;
        dp_output_STB = 1'b1;
        tick();
        dp_output_STB = 1'b0;
        total++; if (rsp_result !== 32'h0 || rsp_err !== 1'b1) begin bad++; $display("FAIL wd_late_stb got result=%h err=%b exp result=0 err=1", rsp_result, rsp_err); end
        $display("txn wd owner=%0d result=%h err=%0d", owner, rsp_result, rsp_err);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL wd_rsp_clear got=%b exp=0000", rsp_valid); end
`else
        repeat (20) tick();
        total++; if (rsp_valid !== 4'b0000 || dp_output_module_BUSY !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL wd_off_noresp got valid=%b busy=%b err=%b exp valid=0000 busy=0 err=0", rsp_valid, dp_output_module_BUSY, rsp_err); end
        rst = 1'b0;
        #1;
        rst = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_dp_busy();
        test_backpressure();
        test_reset_mid();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
